// File: rtl/pad_input_sequencer.sv
// Gamepad report debouncer, link watchdog and coin pulser between the
// USB gamepad receiver and the PACMAN core input ports.
//
// Ports:
//   clk24    : 24 MHz system clock
//   rst      : synchronous reset, active high
//   pad_data : report {R,L,D,U,START,SELECT,B,A}, 1 = pressed
//   pad_ena  : one-cycle strobe, pad_data valid in that cycle
//   joy_n    : {J,R,L,D,U} joystick lines, active low
//   sw       : {C2,S2,C1,S1} cabinet switches, active high
//   led      : accepted report bits [3:0]
//   link_ok  : reports are arriving within the timeout
module pad_input_sequencer #(
    parameter int DEB_REPORTS = 2,
    parameter int TIMEOUT_CYC = 2400000,
    parameter int COIN_CYC    = 1200000
) (
    input  logic       clk24,
    input  logic       rst,
    input  logic [7:0] pad_data,
    input  logic       pad_ena,
    output logic [4:0] joy_n,
    output logic [3:0] sw,
    output logic [3:0] led,
    output logic       link_ok
);

    localparam int DW = $clog2(DEB_REPORTS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(COIN_CYC + 1);

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_REPORTS);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] COIN_LEN = CW'(COIN_CYC);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_REL = 2'd2
    } coin_state_t;

    logic [7:0]    raw;
    logic [7:0]    acc;
    logic [DW-1:0] match_cnt;
    logic [TW-1:0] wd;

    coin_state_t   state;
    coin_state_t   state_nxt;
    logic [CW-1:0] coin_cnt;
    logic [CW-1:0] coin_cnt_nxt;
    logic          coin;

    logic [DW-1:0] cnt_inc;
    logic [DW-1:0] cnt_nxt;
    logic          timeout;
    logic          loss;

    assign cnt_inc = (match_cnt == DEB_MAX) ? match_cnt
                                            : match_cnt + DW'(1);
    assign cnt_nxt = (pad_data == raw) ? cnt_inc : DW'(1);
    assign timeout = (wd == TO_MAX);
    // A strobe arriving on the timeout cycle keeps the link alive.
    assign loss    = timeout && !pad_ena;

    always_ff @(posedge clk24) begin
        if (rst) begin
            raw       <= '0;
            acc       <= '0;
            match_cnt <= '0;
            wd        <= '0;
            link_ok   <= 1'b0;
        end else if (pad_ena) begin
            raw       <= pad_data;
            match_cnt <= cnt_nxt;
            wd        <= '0;
            link_ok   <= 1'b1;
            if (cnt_nxt == DEB_MAX) begin
                acc <= pad_data;
            end
        end else if (timeout) begin
            acc       <= '0;
            match_cnt <= '0;
            link_ok   <= 1'b0;
        end else begin
            wd <= wd + TW'(1);
        end
    end

    // Opposing directions cancel each other out.
    logic ud_clash;
    logic lr_clash;
    logic u_f;
    logic d_f;
    logic l_f;
    logic r_f;

    assign ud_clash = acc[4] & acc[5];
    assign lr_clash = acc[6] & acc[7];
    assign u_f      = acc[4] & ~ud_clash;
    assign d_f      = acc[5] & ~ud_clash;
    assign l_f      = acc[6] & ~lr_clash;
    assign r_f      = acc[7] & ~lr_clash;

    always_ff @(posedge clk24) begin
        if (rst) begin
            joy_n <= 5'b11111;
            sw    <= 4'b0000;
            led   <= 4'b0000;
        end else begin
            joy_n <= ~{acc[0], r_f, l_f, d_f, u_f};
            sw    <= {2'b00, coin, acc[3]};
            led   <= acc[3:0];
        end
    end

    always_ff @(posedge clk24) begin
        if (rst) begin
            state    <= IDLE;
            coin_cnt <= '0;
        end else begin
            state    <= state_nxt;
            coin_cnt <= coin_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        coin_cnt_nxt = coin_cnt;
        coin         = 1'b0;
        case (state)
            IDLE: begin
                if (acc[2] && link_ok) begin
                    coin_cnt_nxt = COIN_LEN;
                    state_nxt    = PULSE;
                end
            end
            PULSE: begin
                coin = 1'b1;
                if (coin_cnt != '0) begin
                    coin_cnt_nxt = coin_cnt - CW'(1);
                end
                if (coin_cnt <= CW'(1)) begin
                    state_nxt = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!acc[2]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (loss) begin
            state_nxt = IDLE;
        end
    end

endmodule

// File: tb/tb_pad_input_sequencer.sv
// Self-checking bench for pad_input_sequencer: directed scenarios plus a
// randomized run against a report-level reference model.
module tb_pad_input_sequencer;

    localparam int TO   = 50;
    localparam int COIN = 8;
    localparam int DEB  = 2;

    logic       clk24 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pad_data = 8'h00;
    logic       pad_ena = 1'b0;
    logic [4:0] joy_n;
    logic [3:0] sw;
    logic [3:0] led;
    logic       link_ok;

    int checks = 0;
    int failures = 0;

    int mon_hi = 0;
    int mon_rise = 0;
    logic mon_prev = 1'b0;

    pad_input_sequencer #(
        .DEB_REPORTS(DEB),
        .TIMEOUT_CYC(TO),
        .COIN_CYC(COIN)
    ) dut (
        .clk24(clk24),
        .rst(rst),
        .pad_data(pad_data),
        .pad_ena(pad_ena),
        .joy_n(joy_n),
        .sw(sw),
        .led(led),
        .link_ok(link_ok)
    );

    always #5 clk24 = ~clk24;

    always @(negedge clk24) begin
        if (sw[1]) mon_hi = mon_hi + 1;
        if (sw[1] && !mon_prev) mon_rise = mon_rise + 1;
        mon_prev = sw[1];
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(input logic e, input logic [7:0] d);
        pad_ena = e;
        pad_data = d;
        @(posedge clk24);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom));
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        checks++;
        if (joy_n !== 5'b11111) begin
            failures++;
            $display("FAIL reset_joy: got %b want 11111", joy_n);
        end
        checks++;
        if (sw !== 4'b0000) begin
            failures++;
            $display("FAIL reset_sw: got %b want 0000", sw);
        end
        checks++;
        if (led !== 4'b0000) begin
            failures++;
            $display("FAIL reset_led: got %b want 0000", led);
        end
        checks++;
        if (link_ok !== 1'b0) begin
            failures++;
            $display("FAIL reset_link: got %b want 0", link_ok);
        end
        rst = 1'b0;
    endtask

    task automatic test_debounce;
        send(8'h10);
        idle(9);
        checks++;
        if (joy_n !== 5'b11111) begin
            failures++;
            $display("FAIL single_report: joy_n %b want 11111", joy_n);
        end
        checks++;
        if (link_ok !== 1'b1) begin
            failures++;
            $display("FAIL link_up: got %b want 1", link_ok);
        end
        send(8'h10);
        checks++;
        if (joy_n !== 5'b11111) begin
            failures++;
            $display("FAIL latency_early: joy_n %b want 11111", joy_n);
        end
        idle(1);
        checks++;
        if (joy_n !== 5'b11110) begin
            failures++;
            $display("FAIL second_report: joy_n %b want 11110", joy_n);
        end
    endtask

    task automatic test_filter;
        send(8'h30);
        send(8'h30);
        idle(1);
        checks++;
        if (joy_n !== 5'b11111 || led !== 4'h0) begin
            failures++;
            $display("FAIL filter_ud: joy_n %b led %h want 11111 0",
                     joy_n, led);
        end
        send(8'hC1);
        send(8'hC1);
        idle(1);
        checks++;
        if (joy_n !== 5'b01111 || led !== 4'h1) begin
            failures++;
            $display("FAIL filter_lr: joy_n %b led %h want 01111 1",
                     joy_n, led);
        end
    endtask

    task automatic test_coin;
        int h0;
        int r0;
        send(8'h00);
        send(8'h00);
        idle(2);
        h0 = mon_hi;
        r0 = mon_rise;
        for (int i = 0; i < 20; i++) begin
            send(8'h04);
            idle(1);
        end
        checks++;
        if (mon_hi - h0 != COIN || mon_rise - r0 != 1) begin
            failures++;
            $display("FAIL coin_held: high=%0d pulses=%0d want %0d 1",
                     mon_hi - h0, mon_rise - r0, COIN);
        end
        send(8'h00);
        send(8'h00);
        idle(3);
        h0 = mon_hi;
        r0 = mon_rise;
        send(8'h04);
        send(8'h04);
        idle(15);
        checks++;
        if (mon_hi - h0 != COIN || mon_rise - r0 != 1) begin
            failures++;
            $display("FAIL coin_repress: high=%0d pulses=%0d want %0d 1",
                     mon_hi - h0, mon_rise - r0, COIN);
        end
        send(8'h00);
        send(8'h00);
        idle(3);
    endtask

    task automatic test_timeout;
        send(8'h08);
        send(8'h08);
        idle(TO);
        checks++;
        if (link_ok !== 1'b1 || sw !== 4'b0001 || led !== 4'b1000) begin
            failures++;
            $display("FAIL before_timeout: link %b sw %b led %b want 1 0001 1000",
                     link_ok, sw, led);
        end
        idle(1);
        checks++;
        if (link_ok !== 1'b0) begin
            failures++;
            $display("FAIL timeout_link: got %b want 0", link_ok);
        end
        idle(1);
        checks++;
        if (sw !== 4'b0000 || joy_n !== 5'b11111 || led !== 4'b0000) begin
            failures++;
            $display("FAIL timeout_release: sw %b joy %b led %b want 0000 11111 0000",
                     sw, joy_n, led);
        end
        send(8'h08);
        checks++;
        if (link_ok !== 1'b1) begin
            failures++;
            $display("FAIL relink: got %b want 1", link_ok);
        end
    endtask

    task automatic test_reset_mid_pulse;
        send(8'h04);
        send(8'h04);
        idle(3);
        checks++;
        if (sw[1] !== 1'b1) begin
            failures++;
            $display("FAIL pulse_started: sw %b want coin bit 1", sw);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++;
        if (sw !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_pulse: sw %b want 0000", sw);
        end
        idle(COIN + 2);
        checks++;
        if (sw !== 4'b0000) begin
            failures++;
            $display("FAIL no_pulse_after_reset: sw %b want 0000", sw);
        end
    endtask

    task automatic test_ena_on_timeout;
        send(8'h00);
        idle(TO);
        send(8'h00);
        checks++;
        if (link_ok !== 1'b1) begin
            failures++;
            $display("FAIL ena_on_timeout: link %b want 1", link_ok);
        end
        idle(TO);
        checks++;
        if (link_ok !== 1'b1) begin
            failures++;
            $display("FAIL wd_cleared: link %b want 1", link_ok);
        end
    endtask

    // Reference model: state in terms of reports seen, quiet time and
    // remaining coin pulse length.
    logic [7:0] m_last;
    int         m_run;
    logic [7:0] m_acc;
    int         m_quiet;
    logic       m_link;
    int         m_pulse;
    logic       m_armed;

    task automatic test_random;
        logic       e;
        logic [7:0] d;
        logic       loss;
        logic       u, dn, l, r;
        logic [4:0] ej;
        logic [3:0] es;
        logic [3:0] el;
        logic [7:0] pool [8];
        pool = '{8'h00, 8'h04, 8'h10, 8'h30, 8'hC1, 8'h08, 8'h24, 8'h8C};
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m_last = 8'h00;
        m_run = 0;
        m_acc = 8'h00;
        m_quiet = 0;
        m_link = 1'b0;
        m_pulse = 0;
        m_armed = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            e = (i % 300 < 230) && ($urandom_range(0, 2) == 0);
            if (!e) d = 8'($urandom);
            else if ($urandom_range(0, 1) == 0) d = m_last;
            else d = pool[$urandom_range(0, 7)];

            u  = m_acc[4] && !m_acc[5];
            dn = m_acc[5] && !m_acc[4];
            l  = m_acc[6] && !m_acc[7];
            r  = m_acc[7] && !m_acc[6];
            ej = ~{m_acc[0], r, l, dn, u};
            es = {2'b00, m_pulse > 0, m_acc[3]};
            el = m_acc[3:0];

            loss = !e && (m_quiet >= TO);
            if (loss) begin
                m_pulse = 0;
                m_armed = 1'b0;
            end else if (m_pulse > 0) begin
                m_pulse--;
                if (m_pulse == 0) m_armed = 1'b1;
            end else if (m_armed) begin
                if (!m_acc[2]) m_armed = 1'b0;
            end else if (m_acc[2] && m_link) begin
                m_pulse = COIN;
            end

            if (e) begin
                if (d == m_last) m_run++;
                else m_run = 1;
                m_last = d;
                if (m_run >= DEB) m_acc = d;
                m_quiet = 0;
                m_link = 1'b1;
            end else if (loss) begin
                m_acc = 8'h00;
                m_run = 0;
                m_link = 1'b0;
            end else begin
                m_quiet++;
            end

            cyc(e, d);
            checks++;
            if (joy_n !== ej || sw !== es || led !== el || link_ok !== m_link) begin
                failures++;
                $display("FAIL random[%0d]: joy %b sw %b led %b link %b want %b %b %b %b",
                         i, joy_n, sw, led, link_ok, ej, es, el, m_link);
            end
        end
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_filter;
        test_coin;
        test_timeout;
        test_reset_mid_pulse;
        test_ena_on_timeout;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
